uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Downstream consumer of the data memory's memory-mapped UART transmit port. Captures each byte the core stores to the UART TX address into a small FIFO. Serialises queued bytes onto a single 8N1 serial line, with a fixed clock-per-bit divider. Reports FIFO occupancy and a sticky overflow flag.

Parameters:
CLKS_PER_BIT, 104, system clock cycles per serial bit (≥2); 104 gives 115200 baud at 12 MHz.
FIFO_DEPTH, 8, FIFO entries; must be a power of two (≥2).
FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset.
uart_tx_out  input  8  byte from data memory UART TX register.
uart_tx_ready  input  1  level flag from data memory; a rising edge marks a new byte.
tx  output  1  serial line, idle high.
tx_busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty.
fifo_empty  output  1  FIFO holds 0 entries.
fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
fifo_level  output  FIFO_AW+1  current entry count, 0..FIFO_DEPTH.
overflow  output  1  sticky; set when a byte is dropped because the FIFO is full.

Behaviour:
- Reset (rst=0, async): tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, fifo_level=0, overflow=0.
- Reset also clears the FIFO pointers, the edge-detect register, the bit/cycle counters and the shift register. FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame immediately: tx returns high without waiting for a clock edge.
- Edge detect: ready_q is a register of uart_tx_ready, reset to 0.
  - push = uart_tx_ready & ~ready_q.
  - uart_tx_out is sampled on the same edge as push.
  - A level held high across several cycles yields exactly one push, whatever the data does meanwhile.
  - A new byte needs uart_tx_ready to drop low for at least one clock first.
- FIFO: circular buffer with wrap-around pointers of FIFO_AW bits.
  - Push is accepted if the FIFO is not full, or if a pop occurs on the same edge.
  - A push onto a full FIFO with no pop drops the byte and sets overflow. overflow clears only on reset.
  - Simultaneous push and pop leaves fifo_level unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, load cycle counter=0, and go to START. A byte pushed at edge E is popped at edge E+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle cycle); otherwise go to IDLE.
- Timing:
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are gap-free.
  - From the first cycle uart_tx_ready is high (at an idle block), tx falls 2 clock edges later: push on the first edge, pop/START on the second.
- tx is driven from a register; no combinational path from the inputs to tx.

Test Plan:
Use CLKS_PER_BIT=4 and FIFO_DEPTH=8 throughout.
1. Hold rst=0 then release -> tx=1, tx_busy=0, fifo_empty=1, fifo_level=0, overflow=0; tx stays 1 for 100 idle cycles.
2. Raise uart_tx_ready one cycle with uart_tx_out=0xA5 -> tx falls 2 edges later. Then the line carries 0 (start), 1,0,1,0,0,1,0,1, 1 (stop), each 4 cycles, 40 cycles total. tx_busy then drops to 0.
3. Hold uart_tx_ready high 3 cycles while uart_tx_out changes 0x11→0x22→0x33 -> exactly one frame, carrying 0x11; fifo_level peaks at 1.
4. Send 10 single-cycle ready pulses, 2 cycles apart, data 0x01..0x0A, starting at idle. 0x01 pops immediately and 0x02..0x09 fill the FIFO -> fifo_full=1. 0x0A is dropped -> overflow=1. Exactly 9 frames (0x01..0x09) are output, and overflow stays 1 afterwards.
5. Queue 0x00 then 0xFF -> the stop bit of the first frame is followed directly by the start bit of the second, with no extra high cycle; combined duration 80 cycles.
6. Pull rst low during bit 3 of a 0x00 frame, with 2 bytes queued -> tx=1 before the next clk edge, and fifo_level=0. After release, no frame is emitted.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-capture inputs plus serial line and FIFO status of the UART transmitter
interface uart_tx_fifo_if #(
    parameter int FIFO_AW = 3
);
    logic [7:0]       uart_tx_out;
    logic             uart_tx_ready;
    logic             tx;
    logic             tx_busy;
    logic             fifo_empty;
    logic             fifo_full;
    logic [FIFO_AW:0] fifo_level;
    logic             overflow;

    modport master (
        output uart_tx_out, uart_tx_ready,
        input  tx, tx_busy, fifo_empty, fifo_full, fifo_level, overflow
    );

    modport slave (
        input  uart_tx_out, uart_tx_ready,
        output tx, tx_busy, fifo_empty, fifo_full, fifo_level, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: queues bytes written to the UART TX port and sends them as gap-free 8N1 frames
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_AW      = 3
) (
    input logic          clk,
    input logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               ready_q;
    logic               overflow_q;
    logic               tx_q;
    logic [CW-1:0]      cnt;
    logic [2:0]         idx;
    logic [7:0]         shift;
    logic               push;
    logic               pop;
    logic               accept;
    logic               bit_end;

    // Rising edge of ready is a new byte; a pop on the same edge frees a slot in a full FIFO
    always_comb begin
        push    = bus.uart_tx_ready & ~ready_q;
        bit_end = cnt == CW'(CLKS_PER_BIT - 1);
        pop     = (level != '0) && (state == IDLE || (state == STOP && bit_end));
        accept  = push && (level != (FIFO_AW + 1)'(FIFO_DEPTH) || pop);
    end

    // Edge detect, FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_q <= 1'b0;
        end else begin
            ready_q <= bus.uart_tx_ready;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (FIFO_AW + 1)'(accept) - (FIFO_AW + 1)'(pop);
            if (push && !accept) overflow_q <= 1'b1;
        end
    end

    // Byte storage; contents are only ever seen through the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bus.uart_tx_out;
    end

    // Frame sequencer with registered tx; STOP chains straight into START when bytes wait
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tx_q  <= 1'b1;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    state <= START;
                    tx_q  <= 1'b0;
                    cnt   <= '0;
                    shift <= mem[rd_ptr];
                end
                START: if (bit_end) begin
                    state <= DATA;
                    cnt   <= '0;
                    idx   <= '0;
                    tx_q  <= shift[0];
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DATA: if (bit_end) begin
                    cnt   <= '0;
                    shift <= shift >> 1;
                    if (idx == 3'd7) begin
                        state <= STOP;
                        tx_q  <= 1'b1;
                    end else begin
                        idx  <= idx + 1'b1;
                        tx_q <= shift[1];
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                STOP: if (!bit_end) begin
                    cnt <= cnt + 1'b1;
                end else if (pop) begin
                    state <= START;
                    tx_q  <= 1'b0;
                    cnt   <= '0;
                    shift <= mem[rd_ptr];
                end else begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs derived from registered state only
    always_comb begin
        bus.tx         = tx_q;
        bus.tx_busy    = state != IDLE || level != '0;
        bus.fifo_empty = level == '0;
        bus.fifo_full  = level == (FIFO_AW + 1)'(FIFO_DEPTH);
        bus.fifo_level = level;
        bus.overflow   = overflow_q;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random byte traffic checked against an edge-time model of the queue and line
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   edge_n = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    int         q_push[$];
    int         q_pop[$];
    logic [7:0] q_byte[$];
    bit         prev_rdy = 1'b0;
    bit         m_ovf = 1'b0;
    int         p0;

    uart_tx_fifo_if #(.FIFO_AW(AW)) bus ();

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .FIFO_AW     (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Count rising edges so the model can reason in edge numbers
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    // Bytes pushed before edge t and not yet popped before it
    function automatic int occ_before(int t);
        int n = 0;
        foreach (q_push[i]) if (q_push[i] < t && q_pop[i] >= t) n++;
        return n;
    endfunction

    function automatic bit pop_at(int t);
        bit f = 1'b0;
        foreach (q_pop[i]) if (q_pop[i] == t) f = 1'b1;
        return f;
    endfunction

    function automatic int level_after(int t);
        int n = 0;
        foreach (q_push[i]) if (q_push[i] <= t && q_pop[i] > t) n++;
        return n;
    endfunction

    function automatic bit framing(int t);
        bit f = 1'b0;
        foreach (q_pop[i]) if (t >= q_pop[i] && t < q_pop[i] + FRAME) f = 1'b1;
        return f;
    endfunction

    // Line level after edge t: start bit, eight data bits LSB first, stop bit, else idle high
    function automatic logic model_tx(int t);
        logic v = 1'b1;
        logic [7:0] b;
        int k;
        foreach (q_pop[i]) if (t >= q_pop[i] && t < q_pop[i] + FRAME) begin
            k = (t - q_pop[i]) / CPB;
            b = q_byte[i];
            v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        end
        return v;
    endfunction

    // A byte sent at edge t is kept if a slot is free (counting a pop at t); it leaves one edge
    // after arriving, or exactly one frame after the previous byte left, whichever is later
    task automatic model_push(input int t, input logic [7:0] b);
        int p;
        int n;
        n = occ_before(t) - (pop_at(t) ? 1 : 0);
        if (n < DEPTH) begin
            p = t + 1;
            if (q_pop.size() > 0 && q_pop[q_pop.size()-1] + FRAME > p) p = q_pop[q_pop.size()-1] + FRAME;
            q_push.push_back(t);
            q_pop.push_back(p);
            q_byte.push_back(b);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_reset();
        q_push.delete();
        q_pop.delete();
        q_byte.delete();
        m_ovf = 1'b0;
        prev_rdy = 1'b0;
    endtask

    task automatic check_all();
        int t;
        t = edge_n;
        chk("tx", model_tx(t) == bus.tx ? 32'(bus.tx) : 32'(bus.tx), 32'(model_tx(t)));
        chk("level", 32'(bus.fifo_level), level_after(t));
        chk("empty", 32'(bus.fifo_empty), 32'(level_after(t) == 0));
        chk("full", 32'(bus.fifo_full), 32'(level_after(t) == DEPTH));
        chk("busy", 32'(bus.tx_busy), 32'(level_after(t) > 0 || framing(t)));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    // One clock: check outputs of the last edge, then set inputs for the next edge
    task automatic cyc(input logic rdy, input logic [7:0] d);
        @(negedge clk);
        check_all();
        bus.uart_tx_ready = rdy;
        bus.uart_tx_out   = d;
        if (rdy && !prev_rdy && rst) model_push(edge_n + 1, d);
        prev_rdy = rdy;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00);
    endtask

    initial begin
        bus.uart_tx_ready = 1'b0;
        bus.uart_tx_out   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(bus.tx), 1);
        chk("rst_busy", 32'(bus.tx_busy), 0);
        chk("rst_empty", 32'(bus.fifo_empty), 1);
        chk("rst_full", 32'(bus.fifo_full), 0);
        chk("rst_level", 32'(bus.fifo_level), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        rst = 1'b1;
        idle(100);

        cyc(1'b1, 8'hA5);
        idle(45);
        chk("a5_done_busy", 32'(bus.tx_busy), 0);

        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        cyc(1'b1, 8'h33);
        idle(45);

        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 8'(i));
            cyc(1'b0, 8'h00);
        end
        chk("burst_full", 32'(bus.fifo_full), 1);
        chk("burst_overflow", 32'(bus.overflow), 1);
        idle(9 * FRAME + 20);
        chk("burst_overflow_sticky", 32'(bus.overflow), 1);
        chk("burst_drained", 32'(bus.fifo_level), 0);

        cyc(1'b1, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'hFF);
        idle(90);

        repeat (250) cyc($urandom_range(0, 3) == 0, 8'($urandom));
        repeat (400) cyc($urandom_range(0, 40) == 0, 8'($urandom));
        idle(9 * FRAME + 20);

        cyc(1'b1, 8'h00);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h5A);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'hC3);
        cyc(1'b0, 8'h00);
        p0 = q_pop[q_pop.size()-3];
        while (edge_n < p0 + 4 * CPB + 1) cyc(1'b0, 8'h00);
        chk("pre_abort_tx", 32'(bus.tx), 0);
        chk("pre_abort_level", 32'(bus.fifo_level), 2);
        #1 rst = 1'b0;
        #1;
        chk("abort_tx", 32'(bus.tx), 1);
        chk("abort_level", 32'(bus.fifo_level), 0);
        chk("abort_busy", 32'(bus.tx_busy), 0);
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        rst = 1'b1;
        idle(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
